// File: rtl/des_pkg.sv
// Shared DES S-layer constants and the serial scheduler state encoding.
package des_pkg;

    localparam int SBOX_IN_W    = 6;
    localparam int SBOX_OUT_W   = 4;
    localparam int NUM_SBOX     = 8;
    localparam int SLAYER_IN_W  = 48;
    localparam int SLAYER_OUT_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sbox_mux_rom.sv
// Combinational DES S-box lookup: sel picks S1..S8, in is the 6-bit chunk.
module sbox_mux_rom
    import des_pkg::*;
(
    input  logic [2:0]            sel,
    input  logic [SBOX_IN_W-1:0]  in,
    output logic [SBOX_OUT_W-1:0] out
);

    // Each table is 64 nibbles, row-major: element 0 is row 0 column 0.
    localparam logic [0:63][3:0] S1 = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
    localparam logic [0:63][3:0] S2 = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
    localparam logic [0:63][3:0] S3 = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
    localparam logic [0:63][3:0] S4 = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
    localparam logic [0:63][3:0] S5 = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
    localparam logic [0:63][3:0] S6 = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
    localparam logic [0:63][3:0] S7 = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
    localparam logic [0:63][3:0] S8 = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;

    logic [5:0] addr;

    // Outer bits select the row, inner four bits the column.
    assign addr = {in[5], in[0], in[4:1]};

    always_comb begin
        out = '0;
        case (sel)
            3'd0:    out = S1[addr];
            3'd1:    out = S2[addr];
            3'd2:    out = S3[addr];
            3'd3:    out = S4[addr];
            3'd4:    out = S5[addr];
            3'd5:    out = S6[addr];
            3'd6:    out = S7[addr];
            default: out = S8[addr];
        endcase
    end

endmodule

// File: rtl/sbox_serial_sched.sv
// Serial DES S-layer: one shared S-box lookup walked across the eight chunks,
// with valid/ready handshakes on both sides.
module sbox_serial_sched
    import des_pkg::*;
#(
    parameter int REG_LOOKUP = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SLAYER_IN_W-1:0]  in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SLAYER_OUT_W-1:0] out_data,
    output logic                    busy
);

    state_t state, state_nx;

    logic [2:0]             idx;
    logic                   issue_done;
    logic [SLAYER_IN_W-1:0] in_latch;
    logic                   accept;
    logic                   issue;
    logic [SBOX_IN_W-1:0]   chunk;
    logic [SBOX_OUT_W-1:0]  lookup;
    logic                   wr_vld;
    logic [2:0]             wr_idx;
    logic [SBOX_OUT_W-1:0]  wr_nib;
    logic                   wr_last;

    assign accept = in_valid && in_ready && !flush;
    assign issue  = (state == RUN) && !issue_done;
    assign chunk  = in_latch[SLAYER_IN_W-1-SBOX_IN_W*idx -: SBOX_IN_W];

    sbox_mux_rom u_rom (
        .sel (idx),
        .in  (chunk),
        .out (lookup)
    );

    // Stage p0 -> p1: optional register between the lookup and the write-back.
    if (REG_LOOKUP != 0) begin : g_reg
        logic                  vld_p1;
        logic [2:0]            idx_p1;
        logic [SBOX_OUT_W-1:0] lookup_p1;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) vld_p1 <= 1'b0;
            else        vld_p1 <= issue && !flush;
        end

        always_ff @(posedge clk) begin
            idx_p1    <= idx;
            lookup_p1 <= lookup;
        end

        assign wr_vld = vld_p1;
        assign wr_idx = idx_p1;
        assign wr_nib = lookup_p1;
    end else begin : g_comb
        assign wr_vld = issue;
        assign wr_idx = idx;
        assign wr_nib = lookup;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (accept) state_nx = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (wr_last) state_nx = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    // idx parks at the last box once issued, so the counter never wraps into a ninth write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            issue_done <= 1'b0;
            wr_last    <= 1'b0;
            in_latch   <= '0;
            out_data   <= '0;
        end else begin
            wr_last <= 1'b0;
            if (flush) begin
                idx        <= '0;
                issue_done <= 1'b0;
            end else begin
                if (accept) begin
                    in_latch   <= in_data;
                    idx        <= '0;
                    issue_done <= 1'b0;
                end
                if (issue) begin
                    if (idx == 3'(NUM_SBOX-1)) issue_done <= 1'b1;
                    else                       idx        <= idx + 3'd1;
                end
                if ((state == RUN) && wr_vld) begin
                    out_data[SLAYER_OUT_W-1-SBOX_OUT_W*wr_idx -: SBOX_OUT_W] <= wr_nib;
                    wr_last <= (wr_idx == 3'(NUM_SBOX-1));
                end
            end
        end
    end

endmodule

// File: tb/tb_sbox_serial_sched.sv
// Randomized self-checking bench for sbox_serial_sched, both lookup variants.
module tb_sbox_serial_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [47:0] in_data = '0;
    logic        iv0 = 1'b0, iv1 = 1'b0;
    logic        or0 = 1'b0, or1 = 1'b0;
    logic        ir0, ir1, ov0, ov1, busy0, busy1;
    logic [31:0] od0, od1;

    int total = 0;
    int bad   = 0;
    int cur   = 0;

    always #5 clk = ~clk;

    sbox_serial_sched #(.REG_LOOKUP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(iv0), .in_ready(ir0), .in_data(in_data),
        .out_valid(ov0), .out_ready(or0), .out_data(od0), .busy(busy0)
    );

    sbox_serial_sched #(.REG_LOOKUP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(iv1), .in_ready(ir1), .in_data(in_data),
        .out_valid(ov1), .out_ready(or1), .out_data(od1), .busy(busy1)
    );

    wire        ir = (cur != 0) ? ir1 : ir0;
    wire        ov = (cur != 0) ? ov1 : ov0;
    wire        bz = (cur != 0) ? busy1 : busy0;
    wire [31:0] od = (cur != 0) ? od1 : od0;

    // Standard DES S-boxes, decimal, [box][row*16+col].
    int sb [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
    };

    function automatic logic [31:0] ref_slayer(input logic [47:0] d);
        logic [31:0] r = '0;
        for (int b = 0; b < 8; b++) begin
            int ch  = int'((d >> (42 - 6*b)) & 48'h3F);
            int row = ((ch >> 5) & 1) * 2 + (ch & 1);
            int col = (ch >> 1) & 15;
            r = (r << 4) | 32'(sb[b][row*16 + col]);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s dut%0d got=%h exp=%h", tag, cur, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_iv(input logic v);
        if (cur != 0) iv1 = v; else iv0 = v;
    endtask

    task automatic set_or(input logic v);
        if (cur != 0) or1 = v; else or0 = v;
    endtask

    // Send one word, hold the result for 'stall' cycles while poking in_valid, then drain.
    task automatic do_word(input logic [47:0] d, input int stall);
        int          lat = -1;
        int          ir_bad = 0;
        int          hold_bad = 0;
        logic [31:0] res;
        logic [31:0] exp = ref_slayer(d);
        set_or(1'b0);
        check("pre_ready", 48'(ir), 48'd1);
        in_data = d;
        set_iv(1'b1);
        step();
        set_iv(1'b0);
        for (int k = 1; k <= 40; k++) begin
            step();
            if (ov) begin
                lat = k;
                break;
            end
            if (ir) ir_bad++;
        end
        check("latency", 48'(lat), 48'((cur != 0) ? 10 : 9));
        res = od;
        check("data", 48'(res), 48'(exp));
        for (int s = 0; s < stall; s++) begin
            in_data = {$urandom, $urandom};
            set_iv(s[0]);
            step();
            if (!ov || od !== res) hold_bad++;
            if (ir) ir_bad++;
        end
        set_iv(1'b0);
        check("hold", 48'(hold_bad), 48'd0);
        set_or(1'b1);
        step();
        set_or(1'b0);
        check("no_overlap", 48'(ir_bad), 48'd0);
        check("back_idle", 48'({ir, ov, bz}), 48'b100);
    endtask

    initial begin
        #2;
        check("rst_ready0", 48'(ir0), 48'd1);
        check("rst_valid0", 48'(ov0), 48'd0);
        check("rst_busy0",  48'(busy0), 48'd0);
        check("rst_data0",  48'(od0), 48'd0);
        check("rst_ready1", 48'(ir1), 48'd1);
        check("rst_data1",  48'(od1), 48'd0);
        step();
        rst_n = 1'b1;
        step();

        for (int sel = 0; sel < 2; sel++) begin
            cur = sel;
            do_word(48'h0, 0);
            do_word(48'hFFFF_FFFF_FFFF, 1);
            for (int n = 0; n < 12; n++) do_word({$urandom, $urandom}, int'($urandom_range(0, 3)));
            do_word(48'h1234_5678_9ABC, 20);
            // Idle after the stalled word: the poked words must not have been taken.
            step();
            check("stall_noaccept", 48'({ir, bz}), 48'b10);

            // Flush with idx at 4.
            in_data = {$urandom, $urandom};
            set_iv(1'b1);
            step();
            set_iv(1'b0);
            for (int k = 0; k < 4; k++) step();
            flush = 1'b1;
            step();
            flush = 1'b0;
            check("flush_state", 48'({ir, ov, bz}), 48'b100);
            do_word(48'h0, 0);

            // Flush in IDLE with in_valid high must not accept.
            in_data = 48'hFFFF_FFFF_FFFF;
            set_iv(1'b1);
            flush = 1'b1;
            step();
            flush = 1'b0;
            set_iv(1'b0);
            check("flush_idle", 48'({ir, bz}), 48'b10);

            // Asynchronous reset between edges, mid-RUN.
            in_data = 48'hA5A5_5A5A_F00F;
            set_iv(1'b1);
            step();
            set_iv(1'b0);
            for (int k = 0; k < 3; k++) step();
            #2 rst_n = 1'b0;
            #1;
            check("arst_outs", 48'({ir, ov, bz}), 48'b100);
            check("arst_data", 48'(od), 48'd0);
            #1 rst_n = 1'b1;
            do_word(48'hA5A5_5A5A_F00F, 0);
            do_word({$urandom, $urandom}, 0);
            do_word(48'h0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
